// File: rtl/loader_pkg.sv
// Shared types and sizing for the program loader: image geometry, byte width
// and the loader state encoding.
package loader_pkg;

    localparam int DATA_W      = 8;
    localparam int IMAGE_DEPTH = 16;
    localparam int CNT_W       = 5;
    localparam int ADDR_W      = $clog2(IMAGE_DEPTH);

    typedef enum logic [1:0] {
        RECEIVE = 2'd0,
        STREAM  = 2'd1,
        DRAIN   = 2'd2,
        RUN     = 2'd3
    } loader_state_e;

    // A byte counter is full once it holds a complete image; counters stop there.
    function automatic logic count_full(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_W'(IMAGE_DEPTH));
    endfunction

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchroniser for an asynchronous strobe followed by a one-clock
// rising-edge pulse taken from the synchronised copy.
module strobe_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic sync3_r;

    // Synchroniser chain plus one history stage for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_r <= RESET_VAL;
            sync2_r <= RESET_VAL;
            sync3_r <= RESET_VAL;
        end else begin
            sync1_r <= async_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign rise = sync2_r & ~sync3_r;

endmodule

// File: rtl/program_loader.sv
// Captures a program image from external pins while the CPU is held in reset,
// then feeds it to the sequencer's load path and hands over at address 0.
module program_loader
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              ext_strobe,
    input  logic              prog_start,
    input  logic              ready,
    input  logic              read_ui_in,
    input  logic              done_load,
    output logic              programming,
    output logic              cpu_resetn,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [CNT_W-1:0]  rx_count,
    output logic              prog_done
);

    loader_state_e      state_r;
    loader_state_e      state_next_s;
    logic [CNT_W-1:0]   rx_count_r;
    logic [CNT_W-1:0]   load_count_r;
    logic [ADDR_W-1:0]  rd_ptr_r;
    logic [DATA_W-1:0]  img_buf_r [IMAGE_DEPTH];
    logic [DATA_W-1:0]  bus_out_r;
    logic               programming_r;
    logic               cpu_resetn_r;
    logic               prog_done_r;
    logic               strobe_rise_s;
    logic               rx_inc_s;
    logic               load_inc_s;
    logic               clear_s;

    strobe_sync #(
        .RESET_VAL (1'b0)
    ) u_strobe_sync (
        .clk      (clk),
        .resetn   (resetn),
        .async_in (ext_strobe),
        .rise     (strobe_rise_s)
    );

    // Next-state and counter-update decisions.
    always_comb begin
        state_next_s = state_r;
        rx_inc_s     = 1'b0;
        load_inc_s   = 1'b0;
        clear_s      = 1'b0;
        case (state_r)
            RECEIVE: begin
                // The full check comes first, so a late edge can never overrun the buffer.
                if (count_full(rx_count_r)) begin
                    state_next_s = STREAM;
                end else if (strobe_rise_s) begin
                    rx_inc_s = 1'b1;
                end else begin
                    state_next_s = RECEIVE;
                end
            end
            STREAM: begin
                if (count_full(load_count_r)) begin
                    state_next_s = DRAIN;
                end else if (done_load) begin
                    load_inc_s = 1'b1;
                end else begin
                    state_next_s = STREAM;
                end
            end
            DRAIN: begin
                // Leaving on T0 drops programming during T1, so T2..T5 of this cycle run normally.
                if (ready) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            RUN: begin
                if (prog_start) begin
                    state_next_s = RECEIVE;
                    clear_s      = 1'b1;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = RECEIVE;
                clear_s      = 1'b1;
            end
        endcase
    end

    // State, counters and handshake outputs, all registered from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= RECEIVE;
            rx_count_r    <= {CNT_W{1'b0}};
            load_count_r  <= {CNT_W{1'b0}};
            rd_ptr_r      <= {ADDR_W{1'b0}};
            programming_r <= 1'b1;
            cpu_resetn_r  <= 1'b0;
            prog_done_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            programming_r <= (state_next_s != RUN);
            cpu_resetn_r  <= (state_next_s != RECEIVE);
            prog_done_r   <= (state_next_s == RUN);
            if (clear_s) begin
                rx_count_r   <= {CNT_W{1'b0}};
                load_count_r <= {CNT_W{1'b0}};
                rd_ptr_r     <= {ADDR_W{1'b0}};
            end else begin
                if (rx_inc_s) begin
                    rx_count_r <= rx_count_r + CNT_W'(1);
                end else begin
                    rx_count_r <= rx_count_r;
                end
                if (load_inc_s) begin
                    load_count_r <= load_count_r + CNT_W'(1);
                    rd_ptr_r     <= rd_ptr_r + ADDR_W'(1);
                end else begin
                    load_count_r <= load_count_r;
                    rd_ptr_r     <= rd_ptr_r;
                end
            end
        end
    end

    // Image storage; contents are only meaningful once captured, so no reset.
    always_ff @(posedge clk) begin
        if (rx_inc_s) begin
            img_buf_r[rx_count_r[ADDR_W-1:0]] <= ext_data;
        end
    end

    // Registered bus byte tracks the read pointer only while streaming.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_out_r <= {DATA_W{1'b0}};
        end else if (state_r == STREAM) begin
            bus_out_r <= img_buf_r[rd_ptr_r];
        end else begin
            bus_out_r <= {DATA_W{1'b0}};
        end
    end

    assign bus_oe      = read_ui_in & (state_r == STREAM);
    assign bus_out     = bus_out_r;
    assign programming = programming_r;
    assign cpu_resetn  = cpu_resetn_r;
    assign prog_done   = prog_done_r;
    assign rx_count    = rx_count_r;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: drives images over the strobe pins,
// plays a sequencer for the load path and compares against a simple image model.
module tb_program_loader;

    logic       clk;
    logic       resetn;
    logic [7:0] ext_data;
    logic       ext_strobe;
    logic       prog_start;
    logic       ready;
    logic       read_ui_in;
    logic       done_load;
    logic       programming;
    logic       cpu_resetn;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [4:0] rx_count;
    logic       prog_done;

    int         n_vec;
    int         n_err;
    logic [7:0] img [16];

    program_loader dut (
        .clk         (clk),
        .resetn      (resetn),
        .ext_data    (ext_data),
        .ext_strobe  (ext_strobe),
        .prog_start  (prog_start),
        .ready       (ready),
        .read_ui_in  (read_ui_in),
        .done_load   (done_load),
        .programming (programming),
        .cpu_resetn  (cpu_resetn),
        .bus_out     (bus_out),
        .bus_oe      (bus_oe),
        .rx_count    (rx_count),
        .prog_done   (prog_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One strobe; rx_before is the model count, counted says whether it should be captured.
    task automatic send_byte(input logic [7:0] b, input int rx_before, input bit counted);
        int rx_after;
        rx_after = counted ? rx_before + 1 : rx_before;
        ext_data = b;
        repeat (3) tick();
        ext_strobe = 1'b1;
        tick();
        tick();
        check("rx_hold", 32'(rx_count), 32'(rx_before));
        tick();
        check("rx_step", 32'(rx_count), 32'(rx_after));
        if (counted && rx_after == 16) begin
            check("cpu_held_at_full", 32'(cpu_resetn), 32'd0);
        end
        tick();
        if (counted && rx_after == 16) begin
            check("cpu_released", 32'(cpu_resetn), 32'd1);
        end
        ext_strobe = 1'b0;
        repeat ($urandom_range(3, 6)) tick();
    endtask

    task automatic capture_image();
        for (int i = 0; i < 16; i++) begin
            send_byte(img[i], i, 1'b1);
        end
    endtask

    // One load instruction cycle T0..T4; byte k of the image must be on the bus at T3.
    task automatic load_cycle(input int k);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        tick();
        check("bus_oe_idle", 32'(bus_oe), 32'd0);
        check("prog_in_stream", 32'(programming), 32'd1);
        read_ui_in = 1'b1;
        #1;
        check("bus_oe_read", 32'(bus_oe), 32'd1);
        check("bus_byte", 32'(bus_out), 32'(img[k]));
        tick();
        read_ui_in = 1'b0;
        done_load  = 1'b1;
        tick();
        done_load  = 1'b0;
    endtask

    task automatic stream_image();
        for (int k = 0; k < 16; k++) begin
            load_cycle(k);
            if (k != 15) begin
                repeat ($urandom_range(1, 3)) tick();
            end
        end
    endtask

    // After the 16th done_load: an extra done_load in DRAIN, then T0 three clocks later.
    task automatic handover();
        tick();
        check("prog_drain1", 32'(programming), 32'd1);
        done_load = 1'b1;
        tick();
        done_load = 1'b0;
        check("prog_drain2", 32'(programming), 32'd1);
        check("cpu_drain", 32'(cpu_resetn), 32'd1);
        check("done_drain", 32'(prog_done), 32'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("prog_fall", 32'(programming), 32'd0);
        check("prog_done", 32'(prog_done), 32'd1);
        check("cpu_run", 32'(cpu_resetn), 32'd1);
        read_ui_in = 1'b1;
        #1;
        check("bus_oe_run", 32'(bus_oe), 32'd0);
        read_ui_in = 1'b0;
        tick();
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        resetn     = 1'b0;
        ext_data   = 8'h00;
        ext_strobe = 1'b0;
        prog_start = 1'b0;
        ready      = 1'b0;
        read_ui_in = 1'b0;
        done_load  = 1'b0;
        repeat (3) tick();
        check("rst_programming", 32'(programming), 32'd1);
        check("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
        check("rst_bus_out", 32'(bus_out), 32'd0);
        check("rst_bus_oe", 32'(bus_oe), 32'd0);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_prog_done", 32'(prog_done), 32'd0);
        resetn = 1'b1;
        tick();

        // prog_start while receiving is ignored
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        tick();
        check("ps_recv_rx", 32'(rx_count), 32'd0);
        check("ps_recv_cpu", 32'(cpu_resetn), 32'd0);

        // First image 0x40..0x4F
        for (int i = 0; i < 16; i++) img[i] = 8'(8'h40 + i);
        capture_image();
        // Strobe during STREAM is discarded
        send_byte(8'hEE, 16, 1'b0);
        check("prog_after_stray", 32'(programming), 32'd1);
        stream_image();
        handover();

        // Strobe during RUN is discarded
        send_byte(8'hDD, 16, 1'b0);
        check("run_kept", 32'(prog_done), 32'd1);

        // Reprogram with 0xA0..0xAF
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        check("reprog_cpu", 32'(cpu_resetn), 32'd0);
        check("reprog_rx", 32'(rx_count), 32'd0);
        check("reprog_prog", 32'(programming), 32'd1);
        check("reprog_done", 32'(prog_done), 32'd0);
        for (int i = 0; i < 16; i++) img[i] = 8'(8'hA0 + i);
        capture_image();
        stream_image();
        handover();

        // Random image, interrupted by reset after 7 loads
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
        capture_image();
        for (int k = 0; k < 7; k++) begin
            load_cycle(k);
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        tick();
        read_ui_in = 1'b1;
        #3;
        resetn = 1'b0;
        #1;
        check("arst_programming", 32'(programming), 32'd1);
        check("arst_cpu_resetn", 32'(cpu_resetn), 32'd0);
        check("arst_bus_oe", 32'(bus_oe), 32'd0);
        check("arst_bus_out", 32'(bus_out), 32'd0);
        check("arst_rx_count", 32'(rx_count), 32'd0);
        check("arst_prog_done", 32'(prog_done), 32'd0);
        read_ui_in = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Fresh random image after reset restarts at rx_count 0
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
        capture_image();
        stream_image();
        handover();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
